qoi_encoder: RTL

QOI_ENCODER -- requirements
Module: qoi_encoder

---
 rtl/qoi_types.sv | 42 ++++
 rtl/qoi_enc_index.sv | 33 +++
 rtl/qoi_encoder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_types.sv
// Shared QOI encoder types: pixel struct, chunk op tags, FSM states and the index hash.
// Chunk buffer depth follows QOI_ENC_RGBA_EN (5 bytes with RGBA chunks, otherwise 4).
package qoi_types;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } pixel_t;

    localparam logic [7:0] OP_INDEX = 8'h00;
    localparam logic [7:0] OP_DIFF  = 8'h40;
    localparam logic [7:0] OP_LUMA  = 8'h80;
    localparam logic [7:0] OP_RUN   = 8'hC0;
    localparam logic [7:0] OP_RGB   = 8'hFE;
    localparam logic [7:0] OP_RGBA  = 8'hFF;

    localparam pixel_t PIX_INIT = pixel_t'(32'h0000_00FF);

`ifdef QOI_ENC_RGBA_EN
    localparam int unsigned CHUNK_BYTES = 5;
`else
    localparam int unsigned CHUNK_BYTES = 4;
`endif
    localparam int unsigned CLEN_W = 3;

    typedef enum logic [1:0] {
        ACCEPT   = 2'd0,
        EMIT_RUN = 2'd1,
        EMIT_PIX = 2'd2,
        END      = 2'd3
    } state_e;

    // (3R+5G+7B+11A) mod 64; only the low 6 bits of the sum matter
    function automatic logic [5:0] qoi_hash(input pixel_t p);
        logic [11:0] s;
        s = 12'(p.r) * 12'd3 + 12'(p.g) * 12'd5 + 12'(p.b) * 12'd7 + 12'(p.a) * 12'd11;
        return s[5:0];
    endfunction

endpackage

// File: rtl/qoi_enc_index.sv
// QOI 64-entry colour index: hash and combinational lookup, synchronous write, bulk clear.
// Entries never written since the last clear read back as all-zero.
module qoi_enc_index
    import qoi_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  pixel_t     pix,
    input  logic       wr_en,
    input  logic       clr,
    output logic [5:0] hash_c,
    output logic       hit_c
);

    logic [63:0] valid;
    pixel_t      mem [64];
    pixel_t      rd_c;

    assign hash_c = qoi_hash(pix);
    assign rd_c   = valid[hash_c] ? mem[hash_c] : '0;
    assign hit_c  = (rd_c == pix);

    always_ff @(posedge clk) begin
        if (wr_en) mem[hash_c] <= pix;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       valid         <= '0;
        else if (clr)   valid         <= '0;
        else if (wr_en) valid[hash_c] <= 1'b1;
    end

endmodule

// File: rtl/qoi_encoder.sv
// Streaming QOI encoder: pixels in, QOI chunk bytes plus 8-byte end marker out.
// Define QOI_ENC_RGBA_EN to honour pix_data[7:0] as alpha and emit RGBA chunks.
module qoi_encoder
    import qoi_types::*;
#(
    parameter int unsigned RUN_MAX = 62
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix_data,
    input  logic        pix_last,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        busy
);

    state_e                      state_q, state_d;
    pixel_t                      prev_q, prev_d, pix_c;
    logic [5:0]                  run_q, run_d, run_inc_c;
    logic [CHUNK_BYTES-1:0][7:0] cbuf_q, cbuf_d, chunk_c;
    logic [CLEN_W-1:0]           clen_q, clen_d, chunk_len_c;
    logic                        pend_q, pend_d, last_q, last_d;
    logic [2:0]                  end_cnt_q, end_cnt_d;
    logic [7:0]                  byte_data_d;
    logic                        byte_valid_d, byte_last_d, pix_ready_d, busy_d;
    logic                        accept_c, out_hs_c, idx_clr_c, hit_c;
    logic [5:0]                  hash_c;
    logic [7:0]                  dr_c, dg_c, db_c, rg_c, bg_c;
    logic                        diff_ok_c, luma_ok_c;

`ifdef QOI_ENC_RGBA_EN
    assign pix_c = pixel_t'(pix_data);
`else
    logic unused_alpha;
    assign unused_alpha = ^pix_data[7:0];
    assign pix_c        = pixel_t'({pix_data[31:8], 8'hFF});
`endif

    assign accept_c = pix_valid && pix_ready;
    assign out_hs_c = byte_valid && byte_ready;

    qoi_enc_index u_index (
        .clk    (clk),
        .rst    (rst),
        .pix    (pix_c),
        .wr_en  (accept_c),
        .clr    (idx_clr_c),
        .hash_c (hash_c),
        .hit_c  (hit_c)
    );

    // Wrap-around channel deltas; range tests are done by biasing into an unsigned window
    assign dr_c      = pix_c.r - prev_q.r;
    assign dg_c      = pix_c.g - prev_q.g;
    assign db_c      = pix_c.b - prev_q.b;
    assign rg_c      = dr_c - dg_c;
    assign bg_c      = db_c - dg_c;
    assign diff_ok_c = (8'(dr_c + 8'd2) < 8'd4) && (8'(dg_c + 8'd2) < 8'd4) &&
                       (8'(db_c + 8'd2) < 8'd4);
    assign luma_ok_c = (8'(dg_c + 8'd32) < 8'd64) && (8'(rg_c + 8'd8) < 8'd16) &&
                       (8'(bg_c + 8'd8) < 8'd16);

    // Pixel chunk for a pixel that differs from prev, byte 0 first
    always_comb begin
        chunk_c     = '0;
        chunk_len_c = CLEN_W'(1);
        if (hit_c) begin
            chunk_c[0] = OP_INDEX | {2'b00, hash_c};
        end
`ifdef QOI_ENC_RGBA_EN
        else if (pix_c.a != prev_q.a) begin
            chunk_c[0]  = OP_RGBA;
            chunk_c[1]  = pix_c.r;
            chunk_c[2]  = pix_c.g;
            chunk_c[3]  = pix_c.b;
            chunk_c[4]  = pix_c.a;
            chunk_len_c = CLEN_W'(5);
        end
`endif
        else if (diff_ok_c) begin
            chunk_c[0] = OP_DIFF | {2'b00, 2'(dr_c + 8'd2), 2'(dg_c + 8'd2), 2'(db_c + 8'd2)};
        end else if (luma_ok_c) begin
            chunk_c[0]  = OP_LUMA | {2'b00, 6'(dg_c + 8'd32)};
            chunk_c[1]  = {4'(rg_c + 8'd8), 4'(bg_c + 8'd8)};
            chunk_len_c = CLEN_W'(2);
        end else begin
            chunk_c[0]  = OP_RGB;
            chunk_c[1]  = pix_c.r;
            chunk_c[2]  = pix_c.g;
            chunk_c[3]  = pix_c.b;
            chunk_len_c = CLEN_W'(4);
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        cbuf_d       = cbuf_q;
        clen_d       = clen_q;
        pend_d       = pend_q;
        last_d       = last_q;
        end_cnt_d    = end_cnt_q;
        byte_data_d  = byte_data;
        byte_valid_d = byte_valid;
        byte_last_d  = byte_last;
        busy_d       = busy;
        idx_clr_c    = 1'b0;
        run_inc_c    = run_q + 6'd1;

        case (state_q)
            ACCEPT: begin
                if (accept_c) begin
                    prev_d = pix_c;
                    busy_d = 1'b1;
                    last_d = pix_last;
                    if (pix_c == prev_q) begin
                        if ((run_inc_c == 6'(RUN_MAX)) || pix_last) begin
                            byte_data_d  = OP_RUN | {2'b00, 6'(run_inc_c - 6'd1)};
                            byte_valid_d = 1'b1;
                            run_d        = '0;
                            pend_d       = 1'b0;
                            state_d      = EMIT_RUN;
                        end else begin
                            run_d = run_inc_c;
                        end
                    end else if (run_q != 6'd0) begin
                        // Close the open run first; the pixel chunk waits in the buffer
                        byte_data_d  = OP_RUN | {2'b00, 6'(run_q - 6'd1)};
                        byte_valid_d = 1'b1;
                        run_d        = '0;
                        pend_d       = 1'b1;
                        cbuf_d       = chunk_c;
                        clen_d       = chunk_len_c;
                        state_d      = EMIT_RUN;
                    end else begin
                        byte_data_d  = chunk_c[0];
                        byte_valid_d = 1'b1;
                        cbuf_d       = chunk_c >> 8;
                        clen_d       = chunk_len_c - CLEN_W'(1);
                        state_d      = EMIT_PIX;
                    end
                end
            end
            EMIT_RUN, EMIT_PIX: begin
                if (out_hs_c) begin
                    if ((state_q == EMIT_RUN && pend_q) || (state_q == EMIT_PIX && clen_q != '0)) begin
                        byte_data_d = cbuf_q[0];
                        cbuf_d      = cbuf_q >> 8;
                        clen_d      = clen_q - CLEN_W'(1);
                        pend_d      = 1'b0;
                        state_d     = EMIT_PIX;
                    end else if (last_q) begin
                        byte_data_d = 8'h00;
                        byte_last_d = 1'b0;
                        end_cnt_d   = '0;
                        state_d     = END;
                    end else begin
                        byte_valid_d = 1'b0;
                        state_d      = ACCEPT;
                    end
                end
            end
            END: begin
                if (out_hs_c) begin
                    if (end_cnt_q == 3'd7) begin
                        // Image closed: restart encoder context for the next image
                        byte_valid_d = 1'b0;
                        byte_last_d  = 1'b0;
                        byte_data_d  = 8'h00;
                        busy_d       = 1'b0;
                        prev_d       = PIX_INIT;
                        run_d        = '0;
                        last_d       = 1'b0;
                        idx_clr_c    = 1'b1;
                        state_d      = ACCEPT;
                    end else begin
                        end_cnt_d   = end_cnt_q + 3'd1;
                        byte_data_d = (end_cnt_q == 3'd6) ? 8'h01 : 8'h00;
                        byte_last_d = (end_cnt_q == 3'd6);
                    end
                end
            end
            default: state_d = ACCEPT;
        endcase

        pix_ready_d = (state_d == ACCEPT) && !byte_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACCEPT;
            prev_q     <= PIX_INIT;
            run_q      <= '0;
            cbuf_q     <= '0;
            clen_q     <= '0;
            pend_q     <= 1'b0;
            last_q     <= 1'b0;
            end_cnt_q  <= '0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            pix_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            cbuf_q     <= cbuf_d;
            clen_q     <= clen_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            end_cnt_q  <= end_cnt_d;
            byte_data  <= byte_data_d;
            byte_valid <= byte_valid_d;
            byte_last  <= byte_last_d;
            pix_ready  <= pix_ready_d;
            busy       <= busy_d;
        end
    end

endmodule
